// File: rtl/ssd_scan_decoder.sv
`default_nettype none
// ============================================================================
// ssd_scan_decoder: rebuilds four hex digits from a multiplexed, active-low
// seven-segment anode/segment bus.  Revision 1.0
// ============================================================================
module ssd_scan_decoder #(
    parameter int SETTLE_CYC = 4,
    parameter int OFF_CYC    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       an0,
    input  logic       an1,
    input  logic       an2,
    input  logic       an3,
    input  logic       err_clr,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dig_valid,
    output logic [3:0] dig_blank,
    output logic       frame_stb,
    output logic       scan_err,
    output logic       display_off
);

    localparam logic [7:0]  C_SETTLE = 8'(SETTLE_CYC);
    localparam logic [19:0] C_OFF    = 20'(OFF_CYC);

    logic [3:0]  s_an_q;
    logic [6:0]  s_seg_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [19:0] idle_q, idle_d;
    logic [3:0]  mask_q;
    logic [3:0]  sh_val_q [4];
    logic [3:0]  sh_valid_q, sh_blank_q;

    logic [10:0] w_raw;
    logic        w_same;
    logic        w_capture;
    logic [3:0]  w_an_low;
    logic        w_single;
    logic        w_multi;
    logic [3:0]  w_dec_val;
    logic        w_dec_valid;
    logic        w_dec_blank;

    assign w_raw     = {an3, an2, an1, an0, a, b, c, d, e, f, g};
    // Comparing the incoming vector against the registered one lets the
    // counter restart on the same edge the new vector is registered.
    assign w_same    = (w_raw == {s_an_q, s_seg_q});
    assign w_capture = w_same && (cnt_q == C_SETTLE - 8'd1);
    assign w_an_low  = ~s_an_q;
    assign w_single  = $onehot(w_an_low);
    assign w_multi   = (w_an_low != 4'd0) && !w_single;

    always_comb begin
        cnt_d = 8'd0;
        if (w_same) begin
            cnt_d = (cnt_q == C_SETTLE) ? cnt_q : cnt_q + 8'd1;
        end
        idle_d = 20'd0;
        if (s_an_q == 4'hF) begin
            idle_d = (idle_q == C_OFF) ? idle_q : idle_q + 20'd1;
        end
    end

    always_comb begin
        w_dec_val   = 4'd0;
        w_dec_valid = 1'b1;
        w_dec_blank = 1'b0;
        case (s_seg_q)
            7'b0000001: w_dec_val = 4'h0;
            7'b1001111: w_dec_val = 4'h1;
            7'b0010010: w_dec_val = 4'h2;
            7'b0000110: w_dec_val = 4'h3;
            7'b1001100: w_dec_val = 4'h4;
            7'b0100100: w_dec_val = 4'h5;
            7'b0100000: w_dec_val = 4'h6;
            7'b0001111: w_dec_val = 4'h7;
            7'b0000000: w_dec_val = 4'h8;
            7'b0000100: w_dec_val = 4'h9;
            7'b0001000: w_dec_val = 4'hA;
            7'b1100000: w_dec_val = 4'hB;
            7'b0110001: w_dec_val = 4'hC;
            7'b1000010: w_dec_val = 4'hD;
            7'b0110000: w_dec_val = 4'hE;
            7'b0111000: w_dec_val = 4'hF;
            7'b1111111: begin
                w_dec_valid = 1'b0;
                w_dec_blank = 1'b1;
            end
            default:    w_dec_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_an_q      <= 4'd0;
            s_seg_q     <= 7'd0;
            cnt_q       <= 8'd0;
            idle_q      <= 20'd0;
            mask_q      <= 4'd0;
            sh_valid_q  <= 4'd0;
            sh_blank_q  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                sh_val_q[i] <= 4'd0;
            end
            digit0      <= 4'd0;
            digit1      <= 4'd0;
            digit2      <= 4'd0;
            digit3      <= 4'd0;
            dig_valid   <= 4'd0;
            dig_blank   <= 4'd0;
            frame_stb   <= 1'b0;
            scan_err    <= 1'b0;
            display_off <= 1'b0;
        end else begin
            s_an_q    <= {an3, an2, an1, an0};
            s_seg_q   <= {a, b, c, d, e, f, g};
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            frame_stb <= (mask_q == 4'hF);

            // A full mask commits the shadows on the following edge; a capture
            // cannot coincide because it needs a fresh multi-cycle dwell.
            if (mask_q == 4'hF) begin
                digit0    <= sh_val_q[0];
                digit1    <= sh_val_q[1];
                digit2    <= sh_val_q[2];
                digit3    <= sh_val_q[3];
                dig_valid <= sh_valid_q;
                dig_blank <= sh_blank_q;
                mask_q    <= 4'd0;
            end else if (w_capture && w_single) begin
                mask_q <= mask_q | w_an_low;
            end

            if (w_capture && w_single) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_an_low[i]) begin
                        sh_val_q[i]   <= w_dec_val;
                        sh_valid_q[i] <= w_dec_valid;
                        sh_blank_q[i] <= w_dec_blank;
                    end
                end
            end

            if (w_capture && w_multi) begin
                scan_err <= 1'b1;
            end else if (err_clr) begin
                scan_err <= 1'b0;
            end

            if (w_capture && w_single) begin
                display_off <= 1'b0;
            end else if (idle_d == C_OFF) begin
                display_off <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_decoder.sv
`default_nettype none
// Bench for ssd_scan_decoder: directed scans, queued expected frames checked
// by a monitor on frame_stb, plus direct checks of error/idle/reset behaviour.
module tb_ssd_scan_decoder;

    localparam int SETTLE = 4;
    localparam int OFFC   = 50;

    localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
    localparam logic [6:0] G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0000100, GA = 7'b0001000, GB = 7'b1100000;
    localparam logic [6:0] GC = 7'b0110001, GD = 7'b1000010, GE = 7'b0110000;
    localparam logic [6:0] GF = 7'b0111000, BLNK = 7'b1111111, BAD = 7'b1010101;

    localparam logic [3:0] S0 = 4'b1110, S1 = 4'b1101, S2 = 4'b1011, S3 = 4'b0111;
    localparam logic [3:0] NONE = 4'b1111;

    logic clk = 1'b0;
    logic rst;
    logic a, b, c, d, e, f, g;
    logic an0, an1, an2, an3;
    logic err_clr;
    logic [3:0] digit0, digit1, digit2, digit3, dig_valid, dig_blank;
    logic frame_stb, scan_err, display_off;

    ssd_scan_decoder #(.SETTLE_CYC(SETTLE), .OFF_CYC(OFFC)) dut (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .an0(an0), .an1(an1), .an2(an2), .an3(an3),
        .err_clr(err_clr),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .dig_valid(dig_valid), .dig_blank(dig_blank),
        .frame_stb(frame_stb), .scan_err(scan_err), .display_off(display_off)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d0, d1, d2, d3, vld, blk;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;
    int   frames = 0;
    logic prev_stb = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                        input logic [3:0] d3, input logic [3:0] vld, input logic [3:0] blk,
                        input int ecyc);
        exp_t x;
        x.d0 = d0; x.d1 = d1; x.d2 = d2; x.d3 = d3; x.vld = vld; x.blk = blk; x.cyc = ecyc;
        q.push_back(x);
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        {an3, an2, an1, an0} = an;
        {a, b, c, d, e, f, g} = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (frame_stb) begin
                frames++;
                if (prev_stb) begin
                    total++;
                    $display("FAIL stb_width: got 2+ cycles expected 1");
                end
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_frame_stb: got 1 expected 0");
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    check("digit0", 32'(digit0), 32'(x.d0));
                    check("digit1", 32'(digit1), 32'(x.d1));
                    check("digit2", 32'(digit2), 32'(x.d2));
                    check("digit3", 32'(digit3), 32'(x.d3));
                    check("dig_valid", 32'(dig_valid), 32'(x.vld));
                    check("dig_blank", 32'(dig_blank), 32'(x.blk));
                    if (x.cyc >= 0) check("stb_latency", 32'(cyc), 32'(x.cyc));
                end
            end
            prev_stb <= frame_stb;
        end else begin
            prev_stb <= 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fb;
        rst = 1'b0;
        err_clr = 1'b0;
        {an3, an2, an1, an0} = NONE;
        {a, b, c, d, e, f, g} = BLNK;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digit0", 32'(digit0), 32'd0);
        check("rst_valid", 32'(dig_valid), 32'd0);
        check("rst_stb", 32'(frame_stb), 32'd0);
        check("rst_err", 32'(scan_err), 32'd0);
        check("rst_off", 32'(display_off), 32'd0);
        rst = 1'b1;
        drive(NONE, BLNK, 3);

        // Frame 1: ordered scan, latency measured from slot 3 application
        drive(S0, G3, 10);
        drive(S1, G5, 10);
        drive(S2, GA, 10);
        push(4'h3, 4'h5, 4'hA, 4'h0, 4'b0111, 4'b1000, cyc + SETTLE + 2);
        drive(S3, BLNK, 10);
        drive(NONE, BLNK, 3);

        // Frame 2: out-of-order scan with a short glitch on slot 1
        push(4'h0, 4'h7, 4'hC, 4'hF, 4'b1111, 4'b0000, -1);
        drive(S3, GF, 10);
        drive(S1, G7, 10);
        drive(S1, G9, 3);
        drive(S0, G0, 10);
        drive(S2, GC, 10);
        drive(NONE, BLNK, 3);

        // Frame 3: a two-anode dwell in the middle must not touch the frame
        push(4'h1, 4'h2, 4'hE, 4'hD, 4'b1111, 4'b0000, -1);
        drive(S0, G1, 10);
        drive(S1, G2, 10);
        drive(4'b1010, G8, 6);
        check("err_set", 32'(scan_err), 32'd1);
        drive(S2, GE, 10);
        drive(S3, GD, 10);
        drive(NONE, BLNK, 3);
        check("err_sticky", 32'(scan_err), 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_clr", 32'(scan_err), 32'd0);
        drive(4'b0101, G8, 4);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_set_wins", 32'(scan_err), 32'd1);
        drive(NONE, BLNK, 3);

        // Frame 4: illegal glyph on slot 2
        push(4'h4, 4'hB, 4'h0, 4'h6, 4'b1011, 4'b0000, -1);
        drive(S0, G4, 10);
        drive(S1, GB, 10);
        drive(S2, BAD, 10);
        drive(S3, G6, 10);
        drive(NONE, BLNK, 3);

        // Idle detection
        drive(S1, G1, 10);
        check("off_before_idle", 32'(display_off), 32'd0);
        drive(NONE, BLNK, OFFC);
        check("off_at_50", 32'(display_off), 32'd0);
        drive(NONE, BLNK, 1);
        check("off_at_51", 32'(display_off), 32'd1);
        drive(S0, G2, 10);
        check("off_cleared", 32'(display_off), 32'd0);

        // Reset mid-frame
        drive(S0, G7, 10);
        drive(S1, G8, 10);
        drive(S2, G9, 10);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_digit0", 32'(digit0), 32'd0);
        check("mid_rst_digit1", 32'(digit1), 32'd0);
        check("mid_rst_digit3", 32'(digit3), 32'd0);
        check("mid_rst_valid", 32'(dig_valid), 32'd0);
        check("mid_rst_blank", 32'(dig_blank), 32'd0);
        check("mid_rst_err", 32'(scan_err), 32'd0);
        check("mid_rst_stb", 32'(frame_stb), 32'd0);
        rst = 1'b1;
        fb = frames;
        drive(S3, G2, 10);
        drive(NONE, BLNK, 5);
        check("no_frame_after_rst", 32'(frames), 32'(fb));

        push(4'h5, 4'h3, 4'h0, 4'h2, 4'b1011, 4'b0100, -1);
        drive(S0, G5, 10);
        drive(S1, G3, 10);
        drive(S2, BLNK, 10);
        drive(NONE, BLNK, 10);

        check("queue_drained", 32'(q.size()), 32'd0);
        check("frame_count", 32'(frames), 32'd5);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
